// File: rtl/mult_arbiter_pkg.sv
// Shared types and arithmetic for the multiplier arbiter: default widths,
// requester slot numbers and the floor-shift/saturate helper.
package mult_arbiter_pkg;

   localparam int BITSIZE_DEF = 16;
   localparam int FRAC_DEF    = 15;

   localparam int REQ_BIQUAD  = 0;
   localparam int REQ_MOD     = 1;
   localparam int REQ_MULT    = 2;
   localparam int REQ_ENV     = 3;

   // Arithmetic right shift (floor) followed by clamping to a signed bits-wide range.
   function automatic logic signed [63:0] sat_shift(
      input logic signed [63:0] product,
      input int                 frac = FRAC_DEF,
      input int                 bits = BITSIZE_DEF
   );
      logic signed [63:0] shifted_s;
      logic signed [63:0] max_s;
      logic signed [63:0] min_s;
      shifted_s = product >>> frac;
      max_s     = (64'sd1 <<< (bits - 32'sd1)) - 64'sd1;
      min_s     = -(64'sd1 <<< (bits - 32'sd1));
      if (shifted_s > max_s) begin
         sat_shift = max_s;
      end else if (shifted_s < min_s) begin
         sat_shift = min_s;
      end else begin
         sat_shift = shifted_s;
      end
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at a rotating pointer,
// pointer moves just past the winner whenever a grant is taken.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          valid
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;

   // Search from the pointer upward, wrapping, and take the first active request.
   always_comb begin
      int cand;
      cand      = 0;
      grant     = '0;
      grant_idx = '0;
      valid     = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr_q) + k >= N) ? int'(ptr_q) + k - N : int'(ptr_q) + k;
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            grant_idx = IW'(cand);
         end else begin
            valid     = valid;
         end
      end
      if (valid) begin
         grant[grant_idx] = 1'b1;
      end else begin
         grant = '0;
      end
   end

   // Next pointer: one past the winner, otherwise unchanged.
   always_comb begin
      if (advance && valid) begin
         ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Time-shares one 3-stage signed fixed-point multiplier among NREQ requesters
// with round-robin issue, registered ack, and a per-requester done pulse.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int BITSIZE = BITSIZE_DEF,
   parameter int NREQ    = 4,
   parameter int FRAC    = FRAC_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*BITSIZE-1:0] in_a,
   input  logic [NREQ*BITSIZE-1:0] in_b,
   output logic [NREQ-1:0]         ack,
   output logic [NREQ-1:0]         done,
   output logic [BITSIZE-1:0]      result,
   output logic                    busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = 2 * BITSIZE;

   logic [NREQ-1:0]           gnt_s;
   logic [IW-1:0]             gnt_idx_s;
   logic                      gnt_valid_s;

   logic                      v1_q, v1_d;
   logic signed [BITSIZE-1:0] a1_q, a1_d;
   logic signed [BITSIZE-1:0] b1_q, b1_d;
   logic [IW-1:0]             id1_q, id1_d;
   logic                      v2_q, v2_d;
   logic signed [PW-1:0]      prod_q, prod_d;
   logic [IW-1:0]             id2_q, id2_d;
   logic [NREQ-1:0]           ack_q, ack_d;
   logic [NREQ-1:0]           done_q, done_d;
   logic [BITSIZE-1:0]        res_q, res_d;
   logic                      busy_q, busy_d;

   // The pipeline accepts one operation every cycle, so the arbiter always advances.
   rr_arbiter #(
      .N(NREQ)
   ) u_rr (
      .clk       (clk),
      .rst_n     (resetn),
      .req       (req),
      .advance   (1'b1),
      .grant     (gnt_s),
      .grant_idx (gnt_idx_s),
      .valid     (gnt_valid_s)
   );

   // Stage next-state: S1 capture, S2 full product, S3 shift/saturate and done.
   always_comb begin
      v1_d  = gnt_valid_s;
      ack_d = gnt_s;
      if (gnt_valid_s) begin
         a1_d  = in_a[int'(gnt_idx_s)*BITSIZE +: BITSIZE];
         b1_d  = in_b[int'(gnt_idx_s)*BITSIZE +: BITSIZE];
         id1_d = gnt_idx_s;
      end else begin
         a1_d  = a1_q;
         b1_d  = b1_q;
         id1_d = id1_q;
      end

      v2_d = v1_q;
      if (v1_q) begin
         prod_d = PW'(a1_q) * PW'(b1_q);
         id2_d  = id1_q;
      end else begin
         prod_d = prod_q;
         id2_d  = id2_q;
      end

      done_d = '0;
      if (v2_q) begin
         done_d[id2_q] = 1'b1;
         res_d         = BITSIZE'(sat_shift(64'(prod_q), FRAC, BITSIZE));
      end else begin
         done_d = '0;
         res_d  = res_q;
      end

      // done_q is the pending S3 output, which is high next cycle exactly when v2_q is now.
      busy_d = v1_d | v2_d | v2_q;
   end

   // Pipeline and output registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v1_q   <= 1'b0;
         a1_q   <= '0;
         b1_q   <= '0;
         id1_q  <= '0;
         v2_q   <= 1'b0;
         prod_q <= '0;
         id2_q  <= '0;
         ack_q  <= '0;
         done_q <= '0;
         res_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         a1_q   <= a1_d;
         b1_q   <= b1_d;
         id1_q  <= id1_d;
         v2_q   <= v2_d;
         prod_q <= prod_d;
         id2_q  <= id2_d;
         ack_q  <= ack_d;
         done_q <= done_d;
         res_q  <= res_d;
         busy_q <= busy_d;
      end
   end

   assign ack    = ack_q;
   assign done   = done_q;
   assign result = res_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus a randomized
// requester population, all compared against a transaction-level model.
module tb_mult_arbiter;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  req    = 4'b0;
   logic [63:0] in_a   = 64'b0;
   logic [63:0] in_b   = 64'b0;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic [15:0] result;
   logic        busy;

   mult_arbiter #(.BITSIZE(16), .NREQ(4), .FRAC(15)) dut (
      .clk    (clk),
      .resetn (resetn),
      .req    (req),
      .in_a   (in_a),
      .in_b   (in_b),
      .ack    (ack),
      .done   (done),
      .result (result),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          id;
      logic [15:0] val;
   } op_t;

   op_t         inflight[$];
   int          mdl_ptr;
   int          cyc;
   int          checks;
   int          passes;
   logic [3:0]  exp_ack;
   logic [3:0]  exp_done;
   logic [15:0] exp_result;
   logic        exp_busy;

   // Q1.15 product: floor of a*b / 2^15, clamped to the 16-bit signed range.
   function automatic logic [15:0] ref_mul(logic [15:0] a, logic [15:0] b);
      longint p;
      longint q;
      p = longint'($signed(a)) * longint'($signed(b));
      q = p / 32768;
      if (p < 0 && (p % 32768) != 0) q = q - 1;
      if (q > 32767) q = 32767;
      else if (q < -32768) q = -32768;
      return q[15:0];
   endfunction

   // First requester at or after the pointer, wrapping; -1 if none.
   function automatic int pick(logic [3:0] r, int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic mdl_reset();
      inflight.delete();
      mdl_ptr    = 0;
      exp_ack    = 4'b0;
      exp_done   = 4'b0;
      exp_result = 16'h0000;
      exp_busy   = 1'b0;
   endtask

   // Advance one clock and update the expected outputs from the model.
   task automatic step();
      int          g;
      logic [15:0] v;
      g = pick(req, mdl_ptr);
      v = 16'h0;
      if (g >= 0) v = ref_mul(in_a[g*16 +: 16], in_b[g*16 +: 16]);
      @(posedge clk);
      #1;
      cyc++;
      exp_ack = 4'b0;
      if (g >= 0) begin
         exp_ack[g] = 1'b1;
         inflight.push_back('{cyc + 2, g, v});
         mdl_ptr = (g + 1) % 4;
      end
      exp_busy = (inflight.size() != 0);
      exp_done = 4'b0;
      if (inflight.size() != 0 && inflight[0].due == cyc) begin
         op_t o;
         o = inflight.pop_front();
         exp_done[o.id] = 1'b1;
         exp_result     = o.val;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      req    = 4'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ack, done, busy, result} !== 25'b0)
         $display("FAIL reset_outputs got ack=%b done=%b busy=%b result=%h want all zero", ack, done, busy, result);
      else passes++;
      @(negedge clk);
      resetn = 1'b1;
      mdl_reset();
      for (int k = 0; k < 6; k++) begin
         if (k == 2) begin
            req = 4'b1111;
            for (int i = 0; i < 4; i++) begin
               in_a[i*16 +: 16] = 16'h1000;
               in_b[i*16 +: 16] = 16'(i * 16'h0800);
            end
         end
         step();
         if (k == 2) begin
            req = 4'b0;
            checks++;
            if (ack !== 4'b0001) $display("FAIL reset_first_grant got=%b want=0001", ack);
            else passes++;
         end
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL reset_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
         checks++;
         if (result !== exp_result) $display("FAIL reset_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
         else passes++;
      end
   endtask

   task automatic test_single();
      req = 4'b0001;
      in_a[15:0] = 16'h4000;
      in_b[15:0] = 16'h4000;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 0) req = 4'b0;
         if (k == 2) begin
            checks++;
            if (done !== 4'b0001 || result !== 16'h2000)
               $display("FAIL single_value got done=%b result=%h want done=0001 result=2000", done, result);
            else passes++;
         end
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL single_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
         checks++;
         if (result !== exp_result) $display("FAIL single_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
         else passes++;
      end
   endtask

   task automatic test_extremes();
      logic [15:0] va[3] = '{16'h8000, 16'h8000, 16'hFFFF};
      logic [15:0] vb[3] = '{16'h8000, 16'h7FFF, 16'h0001};
      logic [15:0] vr[3] = '{16'h7FFF, 16'h8001, 16'hFFFF};
      for (int t = 0; t < 3; t++) begin
         req = 4'b1000;
         in_a[63:48] = va[t];
         in_b[63:48] = vb[t];
         for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) req = 4'b0;
            if (k == 2) begin
               checks++;
               if (done !== 4'b1000 || result !== vr[t])
                  $display("FAIL extreme_%0d got done=%b result=%h want done=1000 result=%h", t, done, result, vr[t]);
               else passes++;
            end
            checks++;
            if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
               $display("FAIL extreme_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
            else passes++;
            checks++;
            if (result !== exp_result) $display("FAIL extreme_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
            else passes++;
         end
      end
   endtask

   task automatic test_round_robin();
      int order[6] = '{0, 1, 2, 3, 0, 1};
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         in_a[i*16 +: 16] = 16'h2000;
         in_b[i*16 +: 16] = 16'(16'h1000 * (i + 1));
      end
      for (int k = 0; k < 9; k++) begin
         step();
         if (k == 5) req = 4'b0;
         if (k < 6) begin
            checks++;
            if (ack !== 4'(1 << order[k])) $display("FAIL rr_order step=%0d got=%b want id %0d", k, ack, order[k]);
            else passes++;
         end
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL rr_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
         checks++;
         if (result !== exp_result) $display("FAIL rr_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      req = 4'b0100;
      in_a[47:32] = 16'($urandom);
      in_b[47:32] = 16'($urandom);
      for (int k = 0; k < 11; k++) begin
         step();
         if (k < 8) begin
            checks++;
            if (ack !== 4'b0100) $display("FAIL b2b_ack step=%0d got=%b want=0100", k, ack);
            else passes++;
            in_a[47:32] = 16'($urandom);
            in_b[47:32] = 16'($urandom);
         end
         if (k == 7) req = 4'b0;
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL b2b_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
         checks++;
         if (result !== exp_result) $display("FAIL b2b_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
         else passes++;
      end
   endtask

   task automatic test_reset_midflight();
      req  = 4'b0111;
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
         step();
         req = req & ~exp_ack;
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL mid_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({ack, done, busy, result} !== 25'b0)
         $display("FAIL mid_reset_outputs got ack=%b done=%b busy=%b result=%h want all zero", ack, done, busy, result);
      else passes++;
      mdl_reset();
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      req    = 4'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            req = 4'b1111;
            in_a[15:0] = 16'h6000;
            in_b[15:0] = 16'hC000;
         end
         step();
         if (k == 4) begin
            req = 4'b0;
            checks++;
            if (ack !== 4'b0001) $display("FAIL mid_ptr_reset got=%b want=0001", ack);
            else passes++;
         end
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL mid_after_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
         checks++;
         if (result !== exp_result) $display("FAIL mid_after_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
         else passes++;
      end
   endtask

   task automatic test_random();
      logic [15:0] edge_v[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
      for (int k = 0; k < 300; k++) begin
         step();
         checks++;
         if ({ack, done, busy} !== {exp_ack, exp_done, exp_busy})
            $display("FAIL rand_hs cyc=%0d got ack=%b done=%b busy=%b want ack=%b done=%b busy=%b", cyc, ack, done, busy, exp_ack, exp_done, exp_busy);
         else passes++;
         checks++;
         if (result !== exp_result) $display("FAIL rand_result cyc=%0d got=%h want=%h", cyc, result, exp_result);
         else passes++;
         for (int i = 0; i < 4; i++) begin
            if (exp_ack[i] || (!req[i] && $urandom_range(0, 2) == 0)) begin
               req[i] = exp_ack[i] ? 1'($urandom_range(0, 1)) : 1'b1;
               in_a[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
               in_b[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
            end
         end
      end
      req = 4'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if ({ack, done, busy, result} !== {exp_ack, exp_done, exp_busy, exp_result})
            $display("FAIL rand_drain cyc=%0d got ack=%b done=%b busy=%b result=%h want ack=%b done=%b busy=%b result=%h", cyc, ack, done, busy, result, exp_ack, exp_done, exp_busy, exp_result);
         else passes++;
      end
   endtask

   initial begin
      checks = 0;
      passes = 0;
      cyc    = 0;
      mdl_reset();
      test_reset();
      test_single();
      test_extremes();
      test_round_robin();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
